seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL: WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL: multiplicand  input  WIDTH  unsigned operand A, captured on the accepted start edge.
REQ-006 SHALL: multiplier  input  WIDTH  unsigned operand B, captured on the accepted start edge.
REQ-007 SHALL: busy  output  1  high while state is BUSY or DONE.
REQ-008 SHALL: done  output  1  one-cycle pulse; product is valid while done is high.
REQ-009 SHALL: product  output  2*WIDTH  registered result; holds the last completed result until the next completion.

Function
REQ-010 SHALL: FSM states: IDLE, BUSY, DONE.
REQ-011 SHALL: IDLE with start=1 at edge k: latch A zero-extended to 2*WIDTH into mcand_sh, latch B into mplier_sh, clear acc, clear count, go to BUSY.
REQ-012 SHALL: IDLE with start=0: remain in IDLE; no register other than the FSM changes.
REQ-013 SHALL: each BUSY edge: if mplier_sh[0]=1 then acc += mcand_sh; then mcand_sh <<= 1, mplier_sh >>= 1, count += 1.
REQ-014 SHALL: acc addition uses the full 2*WIDTH width; no overflow is possible for unsigned operands.
REQ-015 SHALL: BUSY exits to DONE on the edge that processes bit WIDTH-1 (count = WIDTH-1 before the edge); the same edge loads product with the final acc value.
REQ-016 SHALL: with the macro off, the first done-high cycle follows edge k+WIDTH; for WIDTH=4 this is edge k+4.
REQ-017 SHALL: DONE lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
REQ-018 SHALL: start is ignored in BUSY and DONE; operands may change freely without affecting the operation in flight.
REQ-019 SHALL: start high in the first IDLE cycle after DONE is accepted; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-020 SHALL: product is never updated with intermediate partial sums.
REQ-021 SHALL: operand value 0 on either input yields product 0 with normal done signalling.

Reset
REQ-022 SHALL: rst=1 asynchronously forces state IDLE and clears busy, done, product, acc, mcand_sh, mplier_sh and count to 0.
REQ-023 SHALL: rst asserted mid-operation aborts it; no done pulse follows and product reads 0.
REQ-024 SHALL: the first start after rst deasserts is accepted on the first edge at which it is sampled high.

Configuration
REQ-025 SHALL: macro SEQ_MULT_EARLY_TERM_EN enables early termination.
REQ-026 SHALL: when SEQ_MULT_EARLY_TERM_EN is defined, BUSY also exits to DONE on any edge where the shifted multiplier becomes all zeros; product is loaded on that edge.
REQ-027 SHALL: when SEQ_MULT_EARLY_TERM_EN is defined, the first done-high cycle follows edge k+max(1, index of highest set bit of B + 1).
REQ-028 SHALL: when SEQ_MULT_EARLY_TERM_EN is undefined, latency is fixed at WIDTH edges regardless of operand values.
REQ-029 SHALL: product values are identical with and without the macro.

Verification
REQ-030 SHALL: A=13, B=11, start at edge k -> product=8'h8F, done high only after edge k+4, busy high after edges k+1..k+4.
REQ-031 SHALL: A=15, B=15 -> product=8'hE1; A=0, B=9 -> product=8'h00, each with a single done pulse.
REQ-032 SHALL: start held high through BUSY with operands changed to 2 and 3 -> result still from the originally latched operands; a second operation starts the cycle after DONE.
REQ-033 SHALL: rst pulsed after edge k+2 of A=7, B=6 -> busy=0, done never pulses, product=0; the next start with A=7, B=6 -> product=8'h2A.
REQ-034 SHALL: with SEQ_MULT_EARLY_TERM_EN defined, A=9, B=1 -> product=8'h09, done after edge k+1; A=9, B=8 -> product=8'h48, done after edge k+4.
REQ-035 SHALL: exhaustive 256-pair sweep, both macro settings -> product equals A*B for every pair, exactly one done pulse per start.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH cycles.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_sh;
  logic [WIDTH-1:0] mplier_sh;
  logic [CW-1:0]   count;

  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_step;

  always_comb begin
    acc_next    = mplier_sh[0] ? (acc + mcand_sh) : acc;
    mplier_next = mplier_sh >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Nothing left to add once the shifted multiplier is empty.
    last_step   = (count == LastCount) || (mplier_next == '0);
`else
    last_step   = (count == LastCount);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      count     <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_sh <= multiplier;
            acc       <= '0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= StBusy;
          end
        end
        StBusy: begin
          acc       <= acc_next;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_next;
          count     <= count + CW'(1);
          if (last_step) begin
            // Only the final sum ever reaches product.
            product <= acc_next;
            done    <= 1'b1;
            state   <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=4), valid with or without
// SEQ_MULT_EARLY_TERM_EN.
module tb_seq_multiplier;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_pass;
  int n_total;

  seq_multiplier #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [3:0] b);
    int l;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 4; i++) if (b[i]) l = i + 1;
`else
    l = 4;
`endif
    return l;
  endfunction

  // Launch one operation and watch a bounded window; operands are scrambled after capture.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] p_done, output int lat, output int pulses);
    p_done = 8'hxx;
    lat    = -1;
    pulses = 0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat    = i;
          p_done = product;
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++;
    if (product !== 8'h00) $display("FAIL reset_product got %h want 00", product); else n_pass++;
    n_total++;
  endtask

  task automatic test_basic();
    logic exp_busy, exp_done;
    @(negedge clk);
    multiplicand = 4'd13;
    multiplier   = 4'd11;
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (busy !== 1'b1) $display("FAIL basic_busy_k got %b want 1", busy); else n_pass++;
    n_total++;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      exp_busy = (i <= 4);
      exp_done = (i == 4);
      if (busy !== exp_busy) $display("FAIL basic_busy_k+%0d got %b want %b", i, busy, exp_busy);
      else n_pass++;
      n_total++;
      if (done !== exp_done) $display("FAIL basic_done_k+%0d got %b want %b", i, done, exp_done);
      else n_pass++;
      n_total++;
      if (i >= 4) begin
        if (product !== 8'h8F) $display("FAIL basic_product_k+%0d got %h want 8f", i, product);
        else n_pass++;
        n_total++;
      end
    end
  endtask

  task automatic test_values();
    logic [7:0] p;
    int lat, pulses;
    do_op(4'd15, 4'd15, p, lat, pulses);
    if (p !== 8'hE1) $display("FAIL max_product got %h want e1", p); else n_pass++;
    n_total++;
    if (pulses !== 1) $display("FAIL max_pulses got %0d want 1", pulses); else n_pass++;
    n_total++;
    if (product !== 8'hE1) $display("FAIL max_hold got %h want e1", product); else n_pass++;
    n_total++;
    do_op(4'd0, 4'd9, p, lat, pulses);
    if (p !== 8'h00) $display("FAIL zero_a_product got %h want 00", p); else n_pass++;
    n_total++;
    if (pulses !== 1) $display("FAIL zero_a_pulses got %0d want 1", pulses); else n_pass++;
    n_total++;
    if (lat !== 4) $display("FAIL zero_a_latency got %0d want 4", lat); else n_pass++;
    n_total++;
    do_op(4'd9, 4'd0, p, lat, pulses);
    if (p !== 8'h00) $display("FAIL zero_b_product got %h want 00", p); else n_pass++;
    n_total++;
    if (lat !== exp_lat(4'd0)) $display("FAIL zero_b_latency got %0d want %0d", lat, exp_lat(4'd0));
    else n_pass++;
    n_total++;
  endtask

  task automatic test_back_to_back();
    int d1, d2, n_done;
    logic [7:0] p1, p2;
    d1 = -1; d2 = -1; n_done = 0; p1 = 8'hxx; p2 = 8'hxx;
    @(negedge clk);
    multiplicand = 4'd5;
    multiplier   = 4'd6;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multiplicand = 4'd2;
    multiplier   = 4'd3;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (d1 < 0) begin d1 = i; p1 = product; end
        else begin d2 = i; p2 = product; end
      end
      if (d2 >= 0) break;
    end
    @(negedge clk);
    start = 1'b0;
    if (p1 !== 8'h1E) $display("FAIL b2b_first got %h want 1e", p1); else n_pass++;
    n_total++;
    if (p2 !== 8'h06) $display("FAIL b2b_second got %h want 06", p2); else n_pass++;
    n_total++;
    if (d1 !== exp_lat(4'd6)) $display("FAIL b2b_lat1 got %0d want %0d", d1, exp_lat(4'd6));
    else n_pass++;
    n_total++;
    if ((d2 - d1) !== exp_lat(4'd3) + 2)
      $display("FAIL b2b_spacing got %0d want %0d", d2 - d1, exp_lat(4'd3) + 2);
    else n_pass++;
    n_total++;
    if (n_done !== 2) $display("FAIL b2b_pulses got %0d want 2", n_done); else n_pass++;
    n_total++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort();
    int stray;
    logic [7:0] p;
    int lat, pulses;
    stray = 0;
    @(negedge clk);
    multiplicand = 4'd7;
    multiplier   = 4'd6;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_total++;
    if (product !== 8'h00) $display("FAIL abort_product got %h want 00", product); else n_pass++;
    n_total++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    if (stray !== 0) $display("FAIL abort_quiet got %0d want 0", stray); else n_pass++;
    n_total++;
    do_op(4'd7, 4'd6, p, lat, pulses);
    if (p !== 8'h2A) $display("FAIL abort_rerun got %h want 2a", p); else n_pass++;
    n_total++;
  endtask

  task automatic test_early_term();
    logic [7:0] p;
    int lat, pulses;
    do_op(4'd9, 4'd1, p, lat, pulses);
    if (p !== 8'h09) $display("FAIL et_9x1_product got %h want 09", p); else n_pass++;
    n_total++;
    if (lat !== exp_lat(4'd1)) $display("FAIL et_9x1_latency got %0d want %0d", lat, exp_lat(4'd1));
    else n_pass++;
    n_total++;
    do_op(4'd9, 4'd8, p, lat, pulses);
    if (p !== 8'h48) $display("FAIL et_9x8_product got %h want 48", p); else n_pass++;
    n_total++;
    if (lat !== 4) $display("FAIL et_9x8_latency got %0d want 4", lat); else n_pass++;
    n_total++;
  endtask

  task automatic test_sweep();
    logic [7:0] p, want;
    int lat, pulses;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        want = 8'(a * b);
        do_op(4'(a), 4'(b), p, lat, pulses);
        if (p !== want) $display("FAIL sweep_%0dx%0d got %h want %h", a, b, p, want);
        else n_pass++;
        n_total++;
        if (pulses !== 1) $display("FAIL sweep_pulses_%0dx%0d got %0d want 1", a, b, pulses);
        else n_pass++;
        n_total++;
        if (lat !== exp_lat(4'(b)))
          $display("FAIL sweep_lat_%0dx%0d got %0d want %0d", a, b, lat, exp_lat(4'(b)));
        else n_pass++;
        n_total++;
      end
    end
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 4'd0;
    multiplier   = 4'd0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_values();
    test_back_to_back();
    test_abort();
    test_early_term();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
